reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameters (from define.vh): REG_WIDTH=5 (32 regs), DATA_WIDTH=32, ROB_WIDTH=4 (ROB ids 1..ROB_SIZE-1; id 0 = "no tag").
REQ-002 SHALL have: clk_in  input  1  system clock, all state on rising edge.
REQ-003 SHALL have: rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: rdy_in  input  1  global enable; low = state frozen.
REQ-005 SHALL have: rs1_dp_in, rs2_dp_in  input  REG_WIDTH  dispatcher source register indices.
REQ-006 SHALL have: rs1_busy_dp_out, rs2_busy_dp_out  output  1  source renamed to an in-flight ROB entry.
REQ-007 SHALL have: rs1_rob_dp_out, rs2_rob_dp_out  output  ROB_WIDTH  producing ROB id (0 when not busy).
REQ-008 SHALL have: rs1_val_dp_out, rs2_val_dp_out  output  DATA_WIDTH  architectural value.
REQ-009 SHALL have: rdy_dp_in  input  1  rename request; rd_dp_in  input  REG_WIDTH  destination; rob_id_dp_in  input  ROB_WIDTH  allocated ROB id.
REQ-010 SHALL have: rdy_commit_rob_in  input  1  commit valid; dest_rob_in  input  REG_WIDTH; value_rob_in  input  DATA_WIDTH; rob_id_rob_in  input  ROB_WIDTH  committing entry.
REQ-011 SHALL have: refresh_cdb_in  input  1  pipeline flush (mispredict/jump).

Function
REQ-012 SHALL hold per register: value[DATA_WIDTH], busy[1], tag[ROB_WIDTH].
REQ-013 Read ports SHALL be combinational from current state, 0-cycle latency, regardless of rdy_in.
REQ-014 Index 0 SHALL always read busy=0, tag=0, value=0; writes and renames to x0 SHALL be ignored.
REQ-015 Commit (rdy_commit_rob_in=1, rdy_in=1, dest!=0) SHALL write value_rob_in into value[dest] at next edge, unconditionally.
REQ-016 Commit SHALL clear busy/tag of dest only if busy[dest]=1 and tag[dest]==rob_id_rob_in; mismatched tag (newer rename pending) SHALL leave busy/tag unchanged.
REQ-017 Rename (rdy_dp_in=1, rdy_in=1, refresh_cdb_in=0, rd!=0) SHALL set busy[rd]=1, tag[rd]=rob_id_dp_in at next edge.
REQ-018 Rename and commit to same register same cycle: value written per REQ-015; busy=1, tag=rob_id_dp_in (rename wins).
REQ-019 refresh_cdb_in=1 (rdy_in=1) SHALL clear all busy/tag at next edge; a simultaneous commit's value write SHALL still complete; simultaneous rename SHALL be discarded.
REQ-020 rdy_in=0 SHALL suppress commit, rename and refresh updates; all state held.
REQ-021 Commit and rename SHALL each affect at most one register per cycle; no other state transitions exist.

Reset
REQ-022 rst_in low SHALL immediately clear all value, busy and tag to 0, independent of clk_in.
REQ-023 During reset all read outputs SHALL be 0; first update occurs at first rising edge after rst_in deasserts.
REQ-024 Reset mid-rename/commit SHALL discard the in-progress update.

Configuration
REQ-025 Macro COMMIT_BYPASS_EN SHALL control commit-to-read forwarding.
REQ-026 With COMMIT_BYPASS_EN defined: if commit valid (rdy_in=1), dest==rsN, dest!=0, and busy[rsN]=1 with tag==rob_id_rob_in, rsN outputs SHALL show busy=0, tag=0, val=value_rob_in in the same cycle.
REQ-027 Without COMMIT_BYPASS_EN: outputs SHALL reflect registered state only; committed value visible the cycle after commit.

Verification
REQ-028 Reset: rst_in low mid-run -> all rsN outputs 0 immediately; after release, read x5 -> busy=0, val=0.
REQ-029 Rename x5->ROB 3, then commit dest=5 id=3 value=0xDEADBEEF -> next cycle x5 busy=0, tag=0, val=0xDEADBEEF; with COMMIT_BYPASS_EN, same-cycle val=0xDEADBEEF, busy=0.
REQ-030 Rename x5->3, rename x5->7, commit dest=5 id=3 value=0x11 -> x5 val=0x11, busy=1, tag=7.
REQ-031 Same-cycle rename x6->9 and commit dest=6 id=2 value=0x22 (x6 tag=2) -> x6 val=0x22, busy=1, tag=9.
REQ-032 Rename x1->4, x2->5; assert refresh with commit dest=1 id=4 value=0x33 and rename x3->6 -> x1 val=0x33, x1/x2/x3 busy=0, tag=0.
REQ-033 Rename/commit to x0 value=0x44, and any op with rdy_in=0 -> x0 reads 0/not busy; no state change while rdy_in=0.

Source files
------------

// File: rtl/reg_file.sv
// ============================================================================
//  Module   : reg_file
//  Purpose  : Architectural register file with rename tags for a Tomasulo/ROB
//             core. Reads are combinational; rename, commit and flush apply on
//             the rising clock edge. Optional macro COMMIT_BYPASS_EN forwards
//             a matching commit to the read ports in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,

    input  logic [REG_WIDTH-1:0]  rs1_dp_in,
    input  logic [REG_WIDTH-1:0]  rs2_dp_in,
    output logic                  rs1_busy_dp_out,
    output logic                  rs2_busy_dp_out,
    output logic [ROB_WIDTH-1:0]  rs1_rob_dp_out,
    output logic [ROB_WIDTH-1:0]  rs2_rob_dp_out,
    output logic [DATA_WIDTH-1:0] rs1_val_dp_out,
    output logic [DATA_WIDTH-1:0] rs2_val_dp_out,

    input  logic                  rdy_dp_in,
    input  logic [REG_WIDTH-1:0]  rd_dp_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_dp_in,

    input  logic                  rdy_commit_rob_in,
    input  logic [REG_WIDTH-1:0]  dest_rob_in,
    input  logic [DATA_WIDTH-1:0] value_rob_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_rob_in,

    input  logic                  refresh_cdb_in
);

    localparam int NUM_REGS = 1 << REG_WIDTH;
    localparam int ENTRY_W  = 1 + ROB_WIDTH + DATA_WIDTH;

    logic [NUM_REGS-1:0]                 busy;
    logic [NUM_REGS-1:0][ROB_WIDTH-1:0]  tag;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] value;

    logic commit_fire;
    logic commit_match;
    logic rename_fire;

    always_comb begin
        commit_fire  = rdy_in && rdy_commit_rob_in && (dest_rob_in != '0);
        commit_match = busy[dest_rob_in] && (tag[dest_rob_in] == rob_id_rob_in);
        rename_fire  = rdy_in && rdy_dp_in && !refresh_cdb_in && (rd_dp_in != '0);
    end

    // Returns {busy, tag, value} as seen by the dispatcher for one source.
    function automatic logic [ENTRY_W-1:0] lookup(input logic [REG_WIDTH-1:0] idx);
        logic [ENTRY_W-1:0] res;
        if (idx == '0) begin
            res = '0;
        end else begin
            res = {busy[idx], tag[idx], value[idx]};
`ifdef COMMIT_BYPASS_EN
            if (commit_fire && commit_match && (dest_rob_in == idx))
                res = {1'b0, {ROB_WIDTH{1'b0}}, value_rob_in};
`endif
        end
        return res;
    endfunction

    always_comb begin
        {rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out} = lookup(rs1_dp_in);
        {rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out} = lookup(rs2_dp_in);
    end

    // Ordering matters: commit clears first, flush overrides it, and a rename
    // (only possible without flush) overrides a same-register commit clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy  <= '0;
            tag   <= '0;
            value <= '0;
        end else if (rdy_in) begin
            if (commit_fire) begin
                value[dest_rob_in] <= value_rob_in;
                if (commit_match) begin
                    busy[dest_rob_in] <= 1'b0;
                    tag[dest_rob_in]  <= '0;
                end
            end
            if (refresh_cdb_in) begin
                busy <= '0;
                tag  <= '0;
            end else if (rename_fire) begin
                busy[rd_dp_in] <= 1'b1;
                tag[rd_dp_in]  <= rob_id_dp_in;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Scoreboard bench for reg_file (rename, commit, flush, stall, x0).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1_dp_in, rs2_dp_in;
    logic        rs1_busy_dp_out, rs2_busy_dp_out;
    logic [3:0]  rs1_rob_dp_out, rs2_rob_dp_out;
    logic [31:0] rs1_val_dp_out, rs2_val_dp_out;
    logic        rdy_dp_in;
    logic [4:0]  rd_dp_in;
    logic [3:0]  rob_id_dp_in;
    logic        rdy_commit_rob_in;
    logic [4:0]  dest_rob_in;
    logic [31:0] value_rob_in;
    logic [3:0]  rob_id_rob_in;
    logic        refresh_cdb_in;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string       name;
        logic [4:0]  idx;
        logic        busy;
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    reg_file dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .rs1_dp_in         (rs1_dp_in),
        .rs2_dp_in         (rs2_dp_in),
        .rs1_busy_dp_out   (rs1_busy_dp_out),
        .rs2_busy_dp_out   (rs2_busy_dp_out),
        .rs1_rob_dp_out    (rs1_rob_dp_out),
        .rs2_rob_dp_out    (rs2_rob_dp_out),
        .rs1_val_dp_out    (rs1_val_dp_out),
        .rs2_val_dp_out    (rs2_val_dp_out),
        .rdy_dp_in         (rdy_dp_in),
        .rd_dp_in          (rd_dp_in),
        .rob_id_dp_in      (rob_id_dp_in),
        .rdy_commit_rob_in (rdy_commit_rob_in),
        .dest_rob_in       (dest_rob_in),
        .value_rob_in      (value_rob_in),
        .rob_id_rob_in     (rob_id_rob_in),
        .refresh_cdb_in    (refresh_cdb_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic idle();
        rdy_in            = 1'b1;
        rdy_dp_in         = 1'b0;
        rd_dp_in          = '0;
        rob_id_dp_in      = '0;
        rdy_commit_rob_in = 1'b0;
        dest_rob_in       = '0;
        value_rob_in      = '0;
        rob_id_rob_in     = '0;
        refresh_cdb_in    = 1'b0;
    endtask

    // Apply the driven controls at one rising edge, then return all to idle.
    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic push(input string name, input logic [4:0] idx, input logic busy,
                        input logic [3:0] tag, input logic [31:0] val);
        exp_t e;
        e.name = name; e.idx = idx; e.busy = busy; e.tag = tag; e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_queue();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rs1_dp_in = e.idx;
            rs2_dp_in = e.idx;
            #1;
            checks++;
            if ({rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out} !== {e.busy, e.tag, e.val})
                $display("FAIL %s rs1 x%0d: got busy=%b tag=%0d val=%h, want busy=%b tag=%0d val=%h",
                         e.name, e.idx, rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out,
                         e.busy, e.tag, e.val);
            else
                passed++;
            checks++;
            if ({rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out} !== {e.busy, e.tag, e.val})
                $display("FAIL %s rs2 x%0d: got busy=%b tag=%0d val=%h, want busy=%b tag=%0d val=%h",
                         e.name, e.idx, rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out,
                         e.busy, e.tag, e.val);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle();
        #2;
        push("reset_x5", 5'd5, 1'b0, 4'd0, 32'h0);
        push("reset_x31", 5'd31, 1'b0, 4'd0, 32'h0);
        check_queue();
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        // Build state, then pull reset mid-cycle while a commit is pending.
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd3;
        step();
        push("pre_reset_x5", 5'd5, 1'b1, 4'd3, 32'h0);
        check_queue();
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'hAAAA_5555;
        rob_id_rob_in = 4'd3;
        #1;
        rst_in = 1'b0;
        #1;
        push("mid_reset_x5", 5'd5, 1'b0, 4'd0, 32'h0);
        check_queue();
        @(posedge clk_in);
        #2;
        idle();
        rst_in = 1'b1;
        step();
        push("post_reset_x5", 5'd5, 1'b0, 4'd0, 32'h0);
        check_queue();
    endtask

    task automatic test_commit();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd3;
        step();
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'hDEAD_BEEF;
        rob_id_rob_in = 4'd3;
`ifdef COMMIT_BYPASS_EN
        push("commit_bypass_x5", 5'd5, 1'b0, 4'd0, 32'hDEAD_BEEF);
`else
        push("commit_same_cycle_x5", 5'd5, 1'b1, 4'd3, 32'h0);
`endif
        check_queue();
        step();
        push("commit_x5", 5'd5, 1'b0, 4'd0, 32'hDEAD_BEEF);
        check_queue();
    endtask

    task automatic test_stale_commit();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd3;
        step();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd7;
        step();
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'h11;
        rob_id_rob_in = 4'd3;
        step();
        push("stale_commit_x5", 5'd5, 1'b1, 4'd7, 32'h11);
        check_queue();
    endtask

    task automatic test_same_cycle();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd6; rob_id_dp_in = 4'd2;
        step();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd6; rob_id_dp_in = 4'd9;
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd6; value_rob_in = 32'h22;
        rob_id_rob_in = 4'd2;
        step();
        push("rename_wins_x6", 5'd6, 1'b1, 4'd9, 32'h22);
        check_queue();
    endtask

    task automatic test_refresh();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd1; rob_id_dp_in = 4'd4;
        step();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd2; rob_id_dp_in = 4'd5;
        step();
        refresh_cdb_in = 1'b1;
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd1; value_rob_in = 32'h33;
        rob_id_rob_in = 4'd4;
        rdy_dp_in = 1'b1; rd_dp_in = 5'd3; rob_id_dp_in = 4'd6;
        step();
        push("refresh_x1", 5'd1, 1'b0, 4'd0, 32'h33);
        push("refresh_x2", 5'd2, 1'b0, 4'd0, 32'h0);
        push("refresh_x3", 5'd3, 1'b0, 4'd0, 32'h0);
        check_queue();
    endtask

    task automatic test_x0_and_stall();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd0; rob_id_dp_in = 4'd1;
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd0; value_rob_in = 32'h44;
        rob_id_rob_in = 4'd1;
        step();
        push("x0_write", 5'd0, 1'b0, 4'd0, 32'h0);
        check_queue();
        // Prepare x5 busy with tag 7 and value 0x11 again, then stall.
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd7;
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'h11;
        rob_id_rob_in = 4'd1;
        step();
        for (int i = 0; i < 2; i++) begin
            rdy_in = 1'b0;
            rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'h55;
            rob_id_rob_in = 4'd7;
            rdy_dp_in = 1'b1; rd_dp_in = 5'd7; rob_id_dp_in = 4'd8;
            refresh_cdb_in = (i == 1);
            step();
        end
        push("stall_x5", 5'd5, 1'b1, 4'd7, 32'h11);
        push("stall_x7", 5'd7, 1'b0, 4'd0, 32'h0);
        check_queue();
    endtask

    task automatic test_back_to_back();
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd5; value_rob_in = 32'h77;
        rob_id_rob_in = 4'd7;
        step();
        rdy_dp_in = 1'b1; rd_dp_in = 5'd5; rob_id_dp_in = 4'd2;
        rdy_commit_rob_in = 1'b1; dest_rob_in = 5'd8; value_rob_in = 32'h88;
        rob_id_rob_in = 4'd2;
        step();
        push("b2b_x5", 5'd5, 1'b1, 4'd2, 32'h77);
        push("b2b_x8", 5'd8, 1'b0, 4'd0, 32'h88);
        push("b2b_x31", 5'd31, 1'b0, 4'd0, 32'h0);
        check_queue();
    endtask

    initial begin
        rs1_dp_in = '0;
        rs2_dp_in = '0;
        test_reset();
        test_commit();
        test_stale_commit();
        test_same_cycle();
        test_refresh();
        test_x0_and_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
